herald_host_if: RTL and testbench
=================================

Name: herald_host_if

Overview:
- Parametrised successor to the Herald byte-strobe host front end.
- Accepts an 8-bit command, then a command-dependent number of little-endian operands of OPW bits each.
- Launches one compute engine through a start/done handshake, then streams a command-dependent number of result bytes back, LSB first.
- New over the previous generation: parametrised operand width/count/result size, command legality checking, engine timeout, abort, and a readable status byte.

Parameters:
- OPW, 24, operand width in bits; must be a multiple of 8; OPB = OPW/8 bytes per operand.
- MAX_OPS, 2, maximum operands per command (1..4).
- RES_BYTES, 9, width of the result bus in bytes.
- TIMEOUT, 4096, engine wait limit in cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din  in  8  host write data.
- wr_stb  in  1  host write strobe; acts on its rising edge.
- rd_stb  in  1  host read strobe; acts on its rising edge.
- dout  out  8  host read data, registered.
- busy  out  1  high from command accept until results are ready or an error occurs.
- err  out  1  sticky error flag.
- cmd  out  8  latched command, fed to the engine-side decoder.
- cmd_legal  in  1  decoder: cmd is a supported command (combinational from cmd).
- cmd_nops  in  3  decoder: operand count for cmd (0..MAX_OPS).
- cmd_nres  in  4  decoder: result byte count for cmd (0..RES_BYTES).
- operands  out  MAX_OPS*OPW  operand k occupies bits [k*OPW +: OPW].
- start  out  1  one-cycle engine launch pulse.
- done  in  1  engine completion pulse; result is valid in the same cycle.
- result  in  RES_BYTES*8  engine result; byte j is bits [8j +: 8].

Behaviour:
- Reset: clk rising edge with rst=1. Post-reset values:
  - dout=0, busy=0, err=0, cmd=0, operands=0, start=0.
  - State IDLE; strobe history registers=0.
  - rst mid-operation aborts without emitting start.
- Edge detection: wr_e = wr_stb & ~wr_q; rd_e = rd_stb & ~rd_q; wr_q/rd_q are registered each cycle.
- Abort: wr_e and rd_e in the same cycle, in any state →
  - next state IDLE; busy=0; err=0; start suppressed.
  - Any later done from the engine is ignored.
- IDLE:
  - wr_e: latch cmd=din, clear operands, busy=1, go to DECODE.
  - rd_e: dout = status byte {busy, err, ecode[1:0], 4'b0}.
- DECODE (1 cycle):
  - !cmd_legal → ERROR with ecode=01.
  - cmd_nops==0 → LAUNCH.
  - Otherwise → OPERANDS with byte and operand counters at 0.
- OPERANDS: each wr_e writes din into byte bi of operand oi.
  - bi wraps at OPB-1 and oi increments.
  - After the last byte of operand cmd_nops-1 → LAUNCH.
  - rd_e is ignored.
- LAUNCH: start=1 for exactly one cycle; timeout counter cleared; → WAIT.
- WAIT:
  - done → latch result into the internal result register, ri=0, busy=0; then RESULT, or IDLE if cmd_nres==0.
  - Counter reaching TIMEOUT-1 with no done (when TIMEOUT≠0) → ERROR with ecode=10.
  - done and timeout in the same cycle: done wins.
  - wr_e is ignored.
- RESULT:
  - Each rd_e: dout = byte ri of the latched result; ri increments.
  - After byte cmd_nres-1 → IDLE.
  - wr_e during RESULT: the current command is treated as complete; wr_e is processed as a new command, same as in IDLE.
- ERROR:
  - err=1, busy=0.
  - rd_e returns the status byte.
  - wr_e clears err and ecode, then is processed as an IDLE wr_e (new command).
- Out-of-range bytes: bytes ri ≥ RES_BYTES read as 0.
- ecode values: 00 none, 01 illegal command, 10 timeout, 11 reserved.
- dout holds its value between reads; it never changes except on rd_e, abort, or reset.
- A done arriving outside WAIT is ignored.

Test Plan:
- Reset, then rd pulse → dout=0x00, busy=0, err=0, start never asserted.
- Two-operand command (decoder: nops=2, nres=3, OPW=24):
  - Stimulus: wr 0x20; wr 0x01,0x02,0x03; wr 0x04,0x05,0x06.
  - Required: operands = {0x060504, 0x030201}; one start pulse.
  - Engine done with result=0xABCDEF → three reads return 0xEF,0xCD,0xAB; busy falls the cycle after done.
- Zero-operand command (nops=0, nres=0):
  - wr 0x22 → start pulse 2 cycles after wr_e.
  - done → IDLE without any read; status byte reads 0x00.
- Illegal command (cmd_legal=0):
  - wr 0x7F → status read = 0x50 (err=1, ecode=01); start never asserted.
  - Next wr 0x20 clears err.
- Timeout with TIMEOUT=16, engine never responds → err rises 16 cycles after start; status read = 0x60.
- Boundaries:
  - Abort with wr/rd rising together mid-OPERANDS → IDLE, busy=0.
  - 9-byte result read fully (bytes 0..8 correct).
  - done coincident with timeout → result path taken, err=0.

Source files
------------

// File: rtl/herald_host_if_if.sv
// Host byte-strobe bus plus engine-side handshake for the Herald host front end.
// The slave modport is the front end's view; master is the host/engine/decoder side.
interface herald_host_if_if #(
  parameter int OPW       = 24,
  parameter int MAX_OPS   = 2,
  parameter int RES_BYTES = 9
);
  logic [7:0]               din;
  logic                     wr_stb;
  logic                     rd_stb;
  logic [7:0]               dout;
  logic                     busy;
  logic                     err;
  logic [7:0]               cmd;
  logic                     cmd_legal;
  logic [2:0]               cmd_nops;
  logic [3:0]               cmd_nres;
  logic [MAX_OPS*OPW-1:0]   operands;
  logic                     start;
  logic                     done;
  logic [RES_BYTES*8-1:0]   result;

  modport master (
    output din, wr_stb, rd_stb, cmd_legal, cmd_nops, cmd_nres, done, result,
    input  dout, busy, err, cmd, operands, start
  );

  modport slave (
    input  din, wr_stb, rd_stb, cmd_legal, cmd_nops, cmd_nres, done, result,
    output dout, busy, err, cmd, operands, start
  );
endinterface

// File: rtl/herald_host_if.sv
// Herald host front end: command/operand capture, engine launch with timeout,
// LSB-first result readback, abort and status byte.
module herald_host_if #(
  parameter int OPW       = 24,
  parameter int MAX_OPS   = 2,
  parameter int RES_BYTES = 9,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  herald_host_if_if.slave bus
);
  localparam int OPB = OPW / 8;
  localparam int BW  = (OPB > 1) ? $clog2(OPB) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BW-1:0] BLAST = BW'(OPB - 1);
  localparam logic [TW-1:0] TLIM  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_OPS, S_LAUNCH, S_WAIT, S_RESULT, S_ERROR
  } state_t;

  state_t                  r_state, w_nxt;
  logic                    r_wr_q, r_rd_q;
  logic [7:0]              r_dout, r_cmd;
  logic                    r_busy, r_err;
  logic [1:0]              r_ecode;
  logic [MAX_OPS*OPW-1:0]  r_ops;
  logic [BW-1:0]           r_bi;
  logic [2:0]              r_oi;
  logic [3:0]              r_ri;
  logic [TW-1:0]           r_tcnt;
  logic [RES_BYTES*8-1:0]  r_res;
  logic [7:0]              w_rbyte;
  logic w_wr_e, w_rd_e, w_abort, w_accept, w_start, w_ld_res;
  logic w_rd_stat, w_rd_res, w_op_wr, w_to, w_ill;

  assign w_wr_e  = bus.wr_stb & ~r_wr_q;
  assign w_rd_e  = bus.rd_stb & ~r_rd_q;
  assign w_abort = w_wr_e & w_rd_e;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Abort overrides every state, so it also suppresses the launch pulse.
  always_comb begin
    w_nxt     = r_state;
    w_accept  = 1'b0;
    w_start   = 1'b0;
    w_ld_res  = 1'b0;
    w_rd_stat = 1'b0;
    w_rd_res  = 1'b0;
    w_op_wr   = 1'b0;
    w_to      = 1'b0;
    w_ill     = 1'b0;
    if (w_abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (w_wr_e) begin
            w_accept = 1'b1;
            w_nxt    = S_DECODE;
          end else if (w_rd_e) begin
            w_rd_stat = 1'b1;
          end
        end
        S_DECODE: begin
          if (!bus.cmd_legal) begin
            w_ill = 1'b1;
            w_nxt = S_ERROR;
          end else if (bus.cmd_nops == 3'd0) begin
            w_nxt = S_LAUNCH;
          end else begin
            w_nxt = S_OPS;
          end
        end
        S_OPS: begin
          if (w_wr_e) begin
            w_op_wr = 1'b1;
            if (r_bi == BLAST && r_oi == bus.cmd_nops - 3'd1) w_nxt = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          w_start = 1'b1;
          w_nxt   = S_WAIT;
        end
        S_WAIT: begin
          if (bus.done) begin
            w_ld_res = 1'b1;
            w_nxt    = (bus.cmd_nres == 4'd0) ? S_IDLE : S_RESULT;
          end else if (TIMEOUT != 0 && r_tcnt == TLIM) begin
            w_to  = 1'b1;
            w_nxt = S_ERROR;
          end
        end
        S_RESULT: begin
          if (w_wr_e) begin
            w_accept = 1'b1;
            w_nxt    = S_DECODE;
          end else if (w_rd_e) begin
            w_rd_res = 1'b1;
            if (r_ri == bus.cmd_nres - 4'd1) w_nxt = S_IDLE;
          end
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // Result bytes past the engine bus width read as zero.
  always_comb begin
    w_rbyte = 8'h00;
    for (int j = 0; j < RES_BYTES; j++)
      if (r_ri == 4'(j)) w_rbyte = r_res[8*j +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_q  <= 1'b0;
      r_rd_q  <= 1'b0;
      r_dout  <= 8'h00;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ecode <= 2'b00;
      r_cmd   <= 8'h00;
      r_ops   <= '0;
      r_bi    <= '0;
      r_oi    <= 3'd0;
      r_ri    <= 4'd0;
      r_tcnt  <= '0;
    end else begin
      r_wr_q <= bus.wr_stb;
      r_rd_q <= bus.rd_stb;
      if (w_abort) begin
        r_busy  <= 1'b0;
        r_err   <= 1'b0;
        r_ecode <= 2'b00;
      end
      if (w_accept) begin
        r_cmd   <= bus.din;
        r_ops   <= '0;
        r_busy  <= 1'b1;
        r_err   <= 1'b0;
        r_ecode <= 2'b00;
        r_bi    <= '0;
        r_oi    <= 3'd0;
      end
      if (w_ill || w_to) begin
        r_err   <= 1'b1;
        r_busy  <= 1'b0;
        r_ecode <= w_ill ? 2'b01 : 2'b10;
      end
      if (w_op_wr) begin
        for (int k = 0; k < MAX_OPS; k++)
          for (int b = 0; b < OPB; b++)
            if (r_oi == 3'(k) && r_bi == BW'(b)) r_ops[k*OPW + b*8 +: 8] <= bus.din;
        if (r_bi == BLAST) begin
          r_bi <= '0;
          r_oi <= r_oi + 3'd1;
        end else begin
          r_bi <= r_bi + BW'(1);
        end
      end
      if (w_start)                r_tcnt <= '0;
      else if (r_state == S_WAIT) r_tcnt <= r_tcnt + TW'(1);
      if (w_ld_res) begin
        r_ri   <= 4'd0;
        r_busy <= 1'b0;
      end
      if (w_rd_stat) r_dout <= {r_busy, r_err, r_ecode, 4'b0000};
      if (w_rd_res) begin
        r_dout <= w_rbyte;
        r_ri   <= r_ri + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_res) r_res <= bus.result;
  end

  assign bus.dout     = r_dout;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.cmd      = r_cmd;
  assign bus.operands = r_ops;
  assign bus.start    = w_start & ~rst;
endmodule

// File: tb/tb_herald_host_if.sv
// Directed bench for herald_host_if: command/operand capture, launch, readback,
// illegal command, abort, timeout and result-size boundaries.
module tb_herald_host_if;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   start_cnt = 0;
  logic [7:0] rd;
  logic ok;

  always #5 clk = ~clk;

  herald_host_if_if #(.OPW(24), .MAX_OPS(2), .RES_BYTES(9)) hif ();

  herald_host_if #(.OPW(24), .MAX_OPS(2), .RES_BYTES(9), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  // Engine-side decoder model
  always_comb begin
    hif.cmd_legal = 1'b1;
    hif.cmd_nops  = 3'd0;
    hif.cmd_nres  = 4'd0;
    case (hif.cmd)
      8'h20: begin hif.cmd_nops = 3'd2; hif.cmd_nres = 4'd3;  end
      8'h21: begin hif.cmd_nops = 3'd0; hif.cmd_nres = 4'd9;  end
      8'h22: begin hif.cmd_nops = 3'd0; hif.cmd_nres = 4'd0;  end
      8'h23: begin hif.cmd_nops = 3'd1; hif.cmd_nres = 4'd11; end
      default: hif.cmd_legal = 1'b0;
    endcase
  end

  always @(negedge clk) if (hif.start) start_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [7:0] d);
    @(negedge clk);
    hif.din    = d;
    hif.wr_stb = 1'b1;
    @(negedge clk);
    hif.wr_stb = 1'b0;
  endtask

  task automatic host_rd(output logic [7:0] d);
    @(negedge clk);
    hif.rd_stb = 1'b1;
    @(negedge clk);
    hif.rd_stb = 1'b0;
    d = hif.dout;
  endtask

  task automatic wait_start(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hif.start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic engine_done(input logic [71:0] res);
    @(negedge clk);
    hif.done   = 1'b1;
    hif.result = res;
    @(negedge clk);
    hif.done   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_b [11];
    hif.din = 8'h00; hif.wr_stb = 1'b0; hif.rd_stb = 1'b0;
    hif.done = 1'b0; hif.result = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_dout", hif.dout, 8'h00);
    check("rst_busy", hif.busy, 1'b0);
    check("rst_err", hif.err, 1'b0);
    check("rst_cmd", hif.cmd, 8'h00);
    check("rst_ops", hif.operands, 48'h0);
    host_rd(rd);
    check("rst_status", rd, 8'h00);
    check("rst_nostart", start_cnt, 0);

    // Two-operand command, three result bytes
    host_wr(8'h20);
    check("c20_busy", hif.busy, 1'b1);
    for (int i = 1; i <= 6; i++) host_wr(8'(i));
    check("c20_ops", hif.operands, 48'h060504030201);
    wait_start(ok);
    check("c20_start_seen", ok, 1'b1);
    repeat (3) @(negedge clk);
    hif.done = 1'b1;
    hif.result = 72'hABCDEF;
    check("c20_busy_done_cycle", hif.busy, 1'b1);
    @(negedge clk);
    hif.done = 1'b0;
    check("c20_busy_after", hif.busy, 1'b0);
    check("c20_start_cnt", start_cnt, 1);
    host_rd(rd); check("c20_rd0", rd, 8'hEF);
    host_rd(rd); check("c20_rd1", rd, 8'hCD);
    host_rd(rd); check("c20_rd2", rd, 8'hAB);
    repeat (2) @(negedge clk);
    check("c20_dout_hold", hif.dout, 8'hAB);
    host_rd(rd); check("c20_status", rd, 8'h00);

    // Zero-operand command: start two cycles after the write edge
    host_wr(8'h22);
    check("c22_start_early", hif.start, 1'b0);
    @(negedge clk);
    check("c22_start", hif.start, 1'b1);
    @(negedge clk);
    check("c22_start_once", hif.start, 1'b0);
    engine_done(72'h55);
    check("c22_idle_busy", hif.busy, 1'b0);
    host_rd(rd); check("c22_status", rd, 8'h00);
    check("c22_start_cnt", start_cnt, 2);

    // Illegal command
    host_wr(8'h7F);
    repeat (2) @(negedge clk);
    host_rd(rd); check("ill_status", rd, 8'h50);
    check("ill_busy", hif.busy, 1'b0);
    check("ill_nostart", start_cnt, 2);
    host_wr(8'h20);
    check("ill_err_clear", hif.err, 1'b0);
    check("ill_new_busy", hif.busy, 1'b1);

    // Abort in the middle of operand collection
    host_wr(8'h01);
    host_wr(8'h02);
    @(negedge clk);
    hif.wr_stb = 1'b1;
    hif.rd_stb = 1'b1;
    @(negedge clk);
    hif.wr_stb = 1'b0;
    hif.rd_stb = 1'b0;
    check("abort_busy", hif.busy, 1'b0);
    check("abort_dout_hold", hif.dout, 8'h50);
    repeat (5) @(negedge clk);
    check("abort_nostart", start_cnt, 2);
    host_rd(rd); check("abort_idle_status", rd, 8'h00);

    // Engine never answers: 16 full WAIT cycles, then error
    host_wr(8'h22);
    wait_start(ok);
    check("to_start_seen", ok, 1'b1);
    repeat (16) @(negedge clk);
    check("to_err_before", hif.err, 1'b0);
    @(negedge clk);
    check("to_err", hif.err, 1'b1);
    check("to_busy", hif.busy, 1'b0);
    host_rd(rd); check("to_status", rd, 8'h60);

    // Full nine-byte result
    host_wr(8'h21);
    wait_start(ok);
    check("r9_start_seen", ok, 1'b1);
    check("r9_err_clear", hif.err, 1'b0);
    engine_done(72'h998877665544332211);
    for (int j = 0; j < 9; j++) begin
      host_rd(rd);
      check($sformatf("r9_byte%0d", j), rd, 8'(8'h11 * (j + 1)));
    end
    host_rd(rd); check("r9_status", rd, 8'h00);

    // Eleven result bytes from a nine-byte bus: the last two read as zero
    host_wr(8'h23);
    host_wr(8'hAA); host_wr(8'hBB); host_wr(8'hCC);
    check("r11_ops", hif.operands, 48'h000000CCBBAA);
    wait_start(ok);
    check("r11_start_seen", ok, 1'b1);
    engine_done(72'h0807060504030201F0);
    exp_b = '{8'hF0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00};
    for (int j = 0; j < 11; j++) begin
      host_rd(rd);
      check($sformatf("r11_byte%0d", j), rd, exp_b[j]);
    end
    host_rd(rd); check("r11_status", rd, 8'h00);

    // done arrives in the very cycle the timeout would fire
    host_wr(8'h22);
    wait_start(ok);
    check("co_start_seen", ok, 1'b1);
    repeat (16) @(negedge clk);
    hif.done = 1'b1;
    @(negedge clk);
    hif.done = 1'b0;
    check("co_err", hif.err, 1'b0);
    check("co_busy", hif.busy, 1'b0);
    host_rd(rd); check("co_status", rd, 8'h00);
    check("total_starts", start_cnt, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end
endmodule
